// File: rtl/imm_gen_pkg.sv
// Shared definitions for the pipelined immediate generator: format codes,
// the opcodes recognised by auto-decode, and the opcode-to-format decoder.
package imm_gen_pkg;

    typedef logic [2:0] imm_fmt_t;

    localparam imm_fmt_t FMT_I    = 3'b000;
    localparam imm_fmt_t FMT_S    = 3'b001;
    localparam imm_fmt_t FMT_B    = 3'b010;
    localparam imm_fmt_t FMT_U    = 3'b011;
    localparam imm_fmt_t FMT_J    = 3'b100;
    localparam imm_fmt_t FMT_AUTO = 3'b111;
    // Unsupported result code; shares its encoding with the AUTO request.
    localparam imm_fmt_t FMT_ILL  = 3'b111;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;

    // Map a major opcode to its immediate format; anything unknown is illegal.
    function automatic imm_fmt_t decode_opcode(input logic [6:0] opc);
        imm_fmt_t f;
        case (opc)
            OPC_LOAD, OPC_OP_IMM, OPC_OP_IMM_32,
            OPC_JALR, OPC_SYSTEM:             f = FMT_I;
            OPC_STORE:                        f = FMT_S;
            OPC_BRANCH:                       f = FMT_B;
            OPC_LUI, OPC_AUIPC:               f = FMT_U;
            OPC_JAL:                          f = FMT_J;
            default:                          f = FMT_ILL;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/imm_gen_core.sv
// Combinational immediate extractor: assembles the 32-bit immediate for the
// resolved format and sign-extends it to XLEN. Unsupported formats give 0
// with the illegal flag raised.
module imm_gen_core
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    input  imm_fmt_t        fmt,
    output logic [XLEN-1:0] imm,
    output logic            illegal
);

    logic signed [31:0] imm32;

    // Select and reassemble the immediate bit fields for each format
    always_comb begin
        imm32   = '0;
        illegal = 1'b0;
        case (fmt)
            FMT_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
            FMT_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7],
                              instr[30:25], instr[11:8], 1'b0};
            FMT_U:   imm32 = {instr[31:12], 12'b0};
            FMT_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12],
                              instr[20], instr[30:21], 1'b0};
            default: illegal = 1'b1;
        endcase
    end

    // Every format is already sign-correct at 32 bits; widen by sign.
    assign imm = XLEN'(imm32);

endmodule

// File: rtl/imm_gen_pipe.sv
// Two-stage pipelined immediate generator with valid/ready on both sides.
// S1 captures the instruction and the resolved format (auto-decoding the
// opcode when requested); S2 captures the extended immediate and flags.
// Optional feature macro: IMM_GEN_ILLEGAL_CNT_EN adds the saturating
// illegal_cnt output counting illegal results as they are consumed.
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [2:0]      in_imm_src,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal
`ifdef IMM_GEN_ILLEGAL_CNT_EN
    ,
    output logic [15:0]     illegal_cnt
`endif
);

    logic            vld_p1;
    logic [31:0]     instr_p1;
    imm_fmt_t        fmt_p1;

    logic            vld_p2;
    logic [XLEN-1:0] imm_p2;
    imm_fmt_t        fmt_p2;
    logic            ill_p2;

    logic            s2_load;
    imm_fmt_t        fmt_res;
    logic [XLEN-1:0] core_imm;
    logic            core_ill;

    // A stage loads when empty or when its content leaves in the same cycle.
    assign s2_load  = !vld_p2 || out_ready;
    assign in_ready = !vld_p1 || s2_load;

    assign fmt_res = (in_imm_src == FMT_AUTO) ? decode_opcode(in_instr[6:0])
                                              : imm_fmt_t'(in_imm_src);

    // ---- S1: instruction word and resolved format ----
    // S1 occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            vld_p1 <= 1'b0;
        else if (in_ready)
            vld_p1 <= in_valid;
    end

    // S1 payload, captured on acceptance only
    always_ff @(posedge clk) begin
        if (in_ready && in_valid) begin
            instr_p1 <= in_instr;
            fmt_p1   <= fmt_res;
        end
    end

    imm_gen_core #(
        .XLEN (XLEN)
    ) u_core (
        .instr   (instr_p1),
        .fmt     (fmt_p1),
        .imm     (core_imm),
        .illegal (core_ill)
    );

    // ---- S2: extended immediate, format, illegal flag ----
    // S2 occupancy and result; held while the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2 <= 1'b0;
            imm_p2 <= '0;
            fmt_p2 <= FMT_I;
            ill_p2 <= 1'b0;
        end else if (s2_load) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                imm_p2 <= core_imm;
                fmt_p2 <= core_ill ? FMT_ILL : fmt_p1;
                ill_p2 <= core_ill;
            end
        end
    end

    assign out_valid   = vld_p2;
    assign out_imm     = imm_p2;
    assign out_fmt     = fmt_p2;
    assign out_illegal = ill_p2;

`ifdef IMM_GEN_ILLEGAL_CNT_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [15:0] ill_cnt_q;

    // Count illegal results as they are handed to the consumer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ill_cnt_q <= 16'd0;
        else if (vld_p2 && out_ready && ill_p2)
            ill_cnt_q <= sat_inc16(ill_cnt_q);
    end

    assign illegal_cnt = ill_cnt_q;
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: a 32-bit and a 64-bit instance share one input
// stream; a queue-based reference model predicts every result.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_instr;
    logic [2:0]  in_imm_src;

    logic        in_ready_a, in_ready_b;
    logic        out_valid_a, out_valid_b;
    logic [31:0] imm_a;
    logic [63:0] imm_b;
    logic [2:0]  fmt_a, fmt_b;
    logic        ill_a, ill_b;
`ifdef IMM_GEN_ILLEGAL_CNT_EN
    logic [15:0] cnt_a, cnt_b;
`endif

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32)) dut32 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready_a),
        .in_instr    (in_instr),
        .in_imm_src  (in_imm_src),
        .out_valid   (out_valid_a),
        .out_ready   (out_ready),
        .out_imm     (imm_a),
        .out_fmt     (fmt_a),
        .out_illegal (ill_a)
`ifdef IMM_GEN_ILLEGAL_CNT_EN
        ,
        .illegal_cnt (cnt_a)
`endif
    );

    imm_gen_pipe #(.XLEN(64)) dut64 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready_b),
        .in_instr    (in_instr),
        .in_imm_src  (in_imm_src),
        .out_valid   (out_valid_b),
        .out_ready   (out_ready),
        .out_imm     (imm_b),
        .out_fmt     (fmt_b),
        .out_illegal (ill_b)
`ifdef IMM_GEN_ILLEGAL_CNT_EN
        ,
        .illegal_cnt (cnt_b)
`endif
    );

    typedef struct packed {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   m_cnt  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Reference: value of the immediate as a signed integer, 64-bit wide.
    function automatic exp_t ref_model(input logic [31:0] w, input logic [2:0] src);
        exp_t       e;
        longint     v;
        logic [2:0] f;
        f = src;
        if (src == 3'd7) begin
            case (w[6:0])
                7'b0000011, 7'b0010011, 7'b0011011,
                7'b1100111, 7'b1110011:               f = 3'd0;
                7'b0100011:                           f = 3'd1;
                7'b1100011:                           f = 3'd2;
                7'b0110111, 7'b0010111:               f = 3'd3;
                7'b1101111:                           f = 3'd4;
                default:                              f = 3'd7;
            endcase
        end
        e.ill = 1'b0;
        case (f)
            3'd0: v = $signed(w[31:20]);
            3'd1: v = $signed({w[31:25], w[11:7]});
            3'd2: v = $signed({w[31], w[7], w[30:25], w[11:8], 1'b0});
            3'd3: begin v = $signed(w[31:12]); v = v * 4096; end
            3'd4: v = $signed({w[31], w[19:12], w[20], w[30:21], 1'b0});
            default: begin v = 0; f = 3'd7; e.ill = 1'b1; end
        endcase
        e.imm = v;
        e.fmt = f;
        return e;
    endfunction

    // Record each accepted input
    always @(posedge clk) begin
        if (rst_n && in_valid && in_ready_a)
            q.push_back(ref_model(in_instr, in_imm_src));
    end

    // Compare presented outputs with the queue head; pop on consumption
    always @(negedge clk) begin
        if (rst_n) begin
`ifdef IMM_GEN_ILLEGAL_CNT_EN
            chk("illegal_cnt32", cnt_a, m_cnt);
            chk("illegal_cnt64", cnt_b, m_cnt);
`endif
            chk("in_ready32", in_ready_a, (q.size() < 2) || out_ready);
            chk("in_ready64", in_ready_b, (q.size() < 2) || out_ready);
            chk("out_valid64", out_valid_b, out_valid_a);
            if (out_valid_a) begin
                if (q.size() == 0) begin
                    chk("spurious_out", out_valid_a, 64'd0);
                end else begin
                    mon_e = q[0];
                    chk("imm32", imm_a, {32'd0, mon_e.imm[31:0]});
                    chk("imm64", imm_b, mon_e.imm);
                    chk("fmt32", fmt_a, mon_e.fmt);
                    chk("fmt64", fmt_b, mon_e.fmt);
                    chk("ill32", ill_a, mon_e.ill);
                    chk("ill64", ill_b, mon_e.ill);
                    if (out_ready) begin
                        void'(q.pop_front());
                        if (mon_e.ill) m_cnt++;
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] w, input logic [2:0] s);
        in_valid   = 1'b1;
        in_instr   = w;
        in_imm_src = s;
    endtask

    logic [6:0] opc_tab [0:10] = '{7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111,
                                   7'b1110011, 7'b0100011, 7'b1100011, 7'b0110111,
                                   7'b0010111, 7'b1101111, 7'b0110011};

    initial begin
        logic [31:0] w;
        int guard;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        in_instr   = '0;
        in_imm_src = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        chk("rst_out_valid", out_valid_a, 64'd0);
        chk("rst_in_ready", in_ready_a, 64'd1);
        chk("rst_imm", imm_b, 64'd0);
        chk("rst_fmt", fmt_a, 64'd0);
        chk("rst_ill", ill_a, 64'd0);
`ifdef IMM_GEN_ILLEGAL_CNT_EN
        chk("rst_cnt", cnt_a, 64'd0);
`endif

        // I-type via auto-decode, two-cycle latency
        out_ready = 1'b1;
        send(32'hFFF00093, 3'b111);
        step();
        in_valid = 1'b0;
        chk("i_lat1_valid", out_valid_a, 64'd0);
        step();
        chk("i_valid", out_valid_a, 64'd1);
        chk("i_imm", imm_a, 64'hFFFFFFFF);
        chk("i_fmt", fmt_a, 64'd0);
        chk("i_ill", ill_a, 64'd0);
        step();
        chk("i_drained", out_valid_a, 64'd0);

        // S-type
        send(32'hFE112E23, 3'b111);
        step();
        in_valid = 1'b0;
        step();
        chk("s_imm", imm_a, 64'hFFFFFFFC);
        chk("s_fmt", fmt_a, 64'd1);
        step();

        // J, U, U back-to-back
        send(32'h0080006F, 3'b111);
        step();
        send(32'h123452B7, 3'b111);
        step();
        send(32'h800002B7, 3'b111);
        chk("j_imm", imm_a, 64'h8);
        chk("j_fmt", fmt_a, 64'd4);
        step();
        in_valid = 1'b0;
        chk("u_valid", out_valid_a, 64'd1);
        chk("u_imm", imm_a, 64'h12345000);
        chk("u_fmt", fmt_a, 64'd3);
        step();
        chk("u64_imm", imm_b, 64'hFFFFFFFF80000000);
        chk("u32_imm", imm_a, 64'h80000000);
        step();

        // Backpressure with illegal entries
        out_ready = 1'b0;
        send(32'hFFF00093, 3'b111);
        step();
        send(32'h00000033, 3'b111);
        step();
        chk("bp_full_ready", in_ready_a, 64'd0);
        chk("bp_valid", out_valid_a, 64'd1);
        chk("bp_imm", imm_a, 64'hFFFFFFFF);
        send(32'h12345678, 3'b101);
        step();
        chk("bp_still_full", in_ready_a, 64'd0);
        chk("bp_hold_imm", imm_a, 64'hFFFFFFFF);
        out_ready = 1'b1;
        #1;
        chk("bp_ready_chain", in_ready_a, 64'd1);
        step();
        in_valid = 1'b0;
        chk("bp_swap_ready", in_ready_a, 64'd1);
        chk("bp_ill_r", ill_a, 64'd1);
        chk("bp_ill_imm", imm_a, 64'd0);
        chk("bp_ill_fmt", fmt_a, 64'd7);
        step();
        chk("bp_ill_src5", ill_a, 64'd1);
        step();
        chk("bp_empty", out_valid_a, 64'd0);
`ifdef IMM_GEN_ILLEGAL_CNT_EN
        chk("bp_cnt2", cnt_a, 64'd2);
`endif

        // Asynchronous reset with two entries in flight
        out_ready = 1'b0;
        send(32'hFFF00093, 3'b111);
        step();
        send(32'hFE112E23, 3'b111);
        step();
        in_valid = 1'b0;
        chk("rst2_full", out_valid_a, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_valid32", out_valid_a, 64'd0);
        chk("rst_async_valid64", out_valid_b, 64'd0);
        q.delete();
        m_cnt = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        chk("post_rst_ready", in_ready_a, 64'd1);
        for (int i = 0; i < 3; i++) begin
            chk("post_rst_no_stale", out_valid_a, 64'd0);
            step();
        end

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            w = $urandom;
            if ($urandom_range(0, 9) < 8) w[6:0] = opc_tab[$urandom_range(0, 10)];
            in_instr   = w;
            in_imm_src = ($urandom_range(0, 9) < 5) ? 3'b111 : 3'($urandom_range(0, 6));
            in_valid   = ($urandom_range(0, 9) < 7);
            out_ready  = ($urandom_range(0, 9) < 7);
            step();
        end

        in_valid  = 1'b0;
        out_ready = 1'b1;
        guard = 0;
        while (q.size() > 0 && guard < 20) begin
            step();
            guard++;
        end
        chk("drain_queue_empty", 64'(q.size()), 64'd0);
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
